// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM slave model.
//   i2c_state_e : protocol FSM states
//   I2C_ACK     : level a receiver drives on the 9th clock to acknowledge
//   I2C_NACK    : released line (pull-up) on the 9th clock
package i2c_eeprom_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StAckDev,
        StWordAddr,
        StAckAddr,
        StWrData,
        StAckWr,
        StRdData,
        StRdAck
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the raw SCL/SDA bus lines into the clk domain and derives
// bus events from the synchronised values.
//   clk_i      : sampling clock (>= 8x SCL)
//   rst_ni     : asynchronous active-low reset, all flops reset to 1 (idle bus)
//   scl_i      : raw SCL line
//   sda_i      : raw SDA line
//   sda_o      : synchronised SDA level
//   scl_rise_o : one-clk pulse on SCL 0->1
//   scl_fall_o : one-clk pulse on SCL 1->0
//   start_o    : one-clk pulse on SDA 1->0 while SCL high (START / repeated START)
//   stop_o     : one-clk pulse on SDA 0->1 while SCL high (STOP)
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
        end
    end

    assign sda_o      = sda_sync_q;
    assign scl_rise_o = scl_sync_q & ~scl_hist_q;
    assign scl_fall_o = ~scl_sync_q & scl_hist_q;
    // SCL must be high on both samples so an SDA change near an SCL edge is not
    // mistaken for a START/STOP.
    assign start_o    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    assign stop_o     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

endmodule

// File: rtl/i2c_eeprom_model.sv
// Behavioural-but-synthesizable I2C EEPROM slave with an 8-bit word address.
// Supports byte/page writes, current-address reads and random reads; the
// address pointer wraps at MEM_BYTES-1. Memory comes out of reset erased (FF).
//   clk    : sampling clock, at least 8x SCL
//   rst_ni : asynchronous active-low reset; releases SDA immediately
//   scl_io : I2C clock, observed only
//   sda_io : I2C data, open-drain (drives 0 or 'z)
module i2c_eeprom_model
    import i2c_eeprom_pkg::*;
#(
    parameter logic [6:0]  ADDRESS   = 7'b1010000,
    parameter int unsigned MEM_BYTES = 256
) (
    input logic clk,
    input logic rst_ni,
    inout wire  scl_io,
    inout wire  sda_io
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .scl_i      (scl_io),
        .sda_i      (sda_io),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    i2c_state_e  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        rw_q, rw_d;

    logic [7:0]  mem_q [MEM_BYTES];
    logic        mem_we;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;
    logic        last_bit;

    function automatic logic [7:0] ptr_next(input logic [7:0] p);
        return (p == 8'(MEM_BYTES - 1)) ? 8'h00 : p + 8'h01;
    endfunction

    assign rx_byte  = {shift_q[6:0], sda_s};
    assign rd_byte  = mem_q[ptr_q[AW-1:0]];
    assign last_bit = (bit_cnt_q == 4'd7);

    // Open-drain: only ever pull low.
    assign sda_io = sda_oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= 8'h00;
            sda_oe_q  <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            rw_q      <= rw_d;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'hFF;
            end
        end else if (mem_we) begin
            mem_q[ptr_q[AW-1:0]] <= rx_byte;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        rw_d      = rw_q;
        mem_we    = 1'b0;

        if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (start_det) begin
            state_d   = StDevAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;

                StDevAddr: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            bit_cnt_d = 4'd0;
                            rw_d      = rx_byte[0];
                            state_d   = (rx_byte[7:1] == ADDRESS) ? StAckDev : StIdle;
                        end
                    end
                end

                // Ack states span two SCL falls: the first asserts ACK, the
                // second releases it and hands over to the data phase.
                StAckDev: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else if (rw_q) begin
                            state_d   = StRdData;
                            bit_cnt_d = 4'd0;
                            shift_d   = rd_byte;
                            sda_oe_d  = ~rd_byte[7];
                        end else begin
                            state_d   = StWordAddr;
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                        end
                    end
                end

                StWordAddr: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            bit_cnt_d = 4'd0;
                            ptr_d     = rx_byte & 8'(MEM_BYTES - 1);
                            state_d   = StAckAddr;
                        end
                    end
                end

                StAckAddr, StAckWr: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StWrData;
                        end
                    end
                end

                // Commit only on the 8th bit so a START/STOP mid-byte drops it.
                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            bit_cnt_d = 4'd0;
                            mem_we    = 1'b1;
                            ptr_d     = ptr_next(ptr_q);
                            state_d   = StAckWr;
                        end
                    end
                end

                // bit_cnt counts bits already clocked out. A fall with count 0
                // only happens after a master ACK: load the next byte there.
                StRdData: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = StRdAck;
                        end else if (bit_cnt_q == 4'd0) begin
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            ptr_d     = ptr_next(ptr_q);
                            bit_cnt_d = 4'd0;
                            state_d   = StRdData;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end

                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_model.sv
module tb_i2c_eeprom_model;

    logic clk = 1'b0;
    logic rst_ni;
    logic m_scl;
    logic m_sda_low;
    wire  scl_bus;
    wire  sda_bus;

    assign scl_bus = m_scl;
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_eeprom_model #(
        .ADDRESS   (7'h50),
        .MEM_BYTES (256)
    ) dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .scl_io (scl_bus),
        .sda_io (sda_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_ptr;

    typedef struct {
        logic        rd;
        logic [7:0]  dev;
        logic [7:0]  word;
        int          n;
        logic [31:0] data;
        logic [31:0] exp_acks;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'hFF;
        ref_ptr = 8'h00;
    endtask

    task automatic model_write(input logic [7:0] dev, input logic [7:0] word, input int n,
                               input logic [31:0] data, output logic [31:0] exp_acks);
        if (dev[7:1] == 7'h50) begin
            ref_ptr = word;
            for (int k = 0; k < n; k++) begin
                ref_mem[ref_ptr] = data[8*k +: 8];
                ref_ptr = ref_ptr + 8'd1;
            end
            exp_acks = 32'h0;
        end else begin
            exp_acks = (32'd1 << (n + 2)) - 32'd1;
        end
    endtask

    task automatic model_read(input logic [7:0] dev, input logic [7:0] word, input logic use_word,
                              input int n, output logic [31:0] exp_acks,
                              output logic [31:0] exp_rd);
        exp_rd = 32'h0;
        if (dev[7:1] == 7'h50) begin
            if (use_word) ref_ptr = word;
            for (int k = 0; k < n; k++) begin
                exp_rd[8*k +: 8] = ref_mem[ref_ptr];
                if (k < n - 1) ref_ptr = ref_ptr + 8'd1;
            end
            exp_acks = 32'h0;
        end else begin
            for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = 8'hFF;
            exp_acks = use_word ? 32'h7 : 32'h1;
        end
    endtask

    // ---------------- bus master (SCL period 160 ns = 16 clk) ----------------
    task automatic start_cond();
        if (m_scl == 1'b0) begin
            #20 m_sda_low = 1'b0;
            #60 m_scl = 1'b1;
            #80;
        end else begin
            #80;
        end
        m_sda_low = 1'b1;
        #80 m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        #20 m_sda_low = 1'b1;
        #60 m_scl = 1'b1;
        #80 m_sda_low = 1'b0;
        #80;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            #20 m_sda_low = ~b[i];
            #60 m_scl = 1'b1;
            #80 m_scl = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        #20 m_sda_low = 1'b0;
        #60 m_scl = 1'b1;
        #40 ack = sda_bus;
        #40 m_scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #80 m_scl = 1'b1;
            #40 b[i] = sda_bus;
            #40 m_scl = 1'b0;
        end
        #20 m_sda_low = ~nack;
        #60 m_scl = 1'b1;
        #80 m_scl = 1'b0;
        #20 m_sda_low = 1'b0;
    endtask

    task automatic read_bytes(input int n, output logic [31:0] rd);
        logic [7:0] b;
        rd = 32'h0;
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, b);
            rd[8*k +: 8] = b;
        end
        #40 check("nack_release", {31'h0, sda_bus}, 32'h1);
    endtask

    task automatic xfer_write(input logic [7:0] dev, input logic [7:0] word, input int n,
                              input logic [31:0] data, output logic [31:0] acks);
        logic a;
        acks = 32'h0;
        start_cond();
        write_byte(dev & 8'hFE, a); acks[0] = a;
        write_byte(word, a);        acks[1] = a;
        for (int k = 0; k < n; k++) begin
            write_byte(data[8*k +: 8], a);
            acks[k + 2] = a;
        end
        stop_cond();
    endtask

    task automatic xfer_rand_read(input logic [7:0] dev, input logic [7:0] word, input int n,
                                  output logic [31:0] acks, output logic [31:0] rd);
        logic a;
        acks = 32'h0;
        start_cond();
        write_byte(dev & 8'hFE, a); acks[0] = a;
        write_byte(word, a);        acks[1] = a;
        start_cond();
        write_byte(dev | 8'h01, a); acks[2] = a;
        read_bytes(n, rd);
        stop_cond();
    endtask

    task automatic xfer_cur_read(input logic [7:0] dev, input int n,
                                 output logic [31:0] acks, output logic [31:0] rd);
        logic a;
        start_cond();
        write_byte(dev | 8'h01, a);
        acks = {31'h0, a};
        read_bytes(n, rd);
        stop_cond();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] acks, rd, e_acks, e_rd;
        logic        a;
        logic [7:0]  dev, word;
        logic [31:0] data;
        int          n, op;

        vecs[0] = '{1'b0, 8'hA0, 8'h10, 2, 32'h0000C35A, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 8'hA0, 8'h10, 2, 32'h0,        32'h0, 32'h0000C35A};
        vecs[2] = '{1'b0, 8'hA2, 8'h10, 1, 32'h00000077, 32'h7, 32'h0};
        vecs[3] = '{1'b1, 8'hA0, 8'h10, 2, 32'h0,        32'h0, 32'h0000C35A};
        vecs[4] = '{1'b0, 8'hA0, 8'hFF, 2, 32'h00002211, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 8'hA0, 8'hFF, 2, 32'h0,        32'h0, 32'h00002211};
        vecs[6] = '{1'b1, 8'hA0, 8'h00, 1, 32'h0,        32'h0, 32'h00000022};

        m_scl     = 1'b1;
        m_sda_low = 1'b0;
        rst_ni    = 1'b0;
        model_reset();
        #53 rst_ni = 1'b1;
        #100;
        check("reset_sda_released", {31'h0, sda_bus}, 32'h1);

        // Erased memory, pointer 0 after reset.
        xfer_cur_read(8'hA1, 1, acks, rd);
        check("reset_cur_read_ack", acks, 32'h0);
        check("reset_cur_read_data", rd, 32'hFF);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].rd) begin
                xfer_rand_read(vecs[v].dev, vecs[v].word, vecs[v].n, acks, rd);
                model_read(vecs[v].dev, vecs[v].word, 1'b1, vecs[v].n, e_acks, e_rd);
                check($sformatf("vec%0d_acks", v), acks, vecs[v].exp_acks);
                check($sformatf("vec%0d_data", v), rd, vecs[v].exp_rd);
            end else begin
                xfer_write(vecs[v].dev, vecs[v].word, vecs[v].n, vecs[v].data, acks);
                model_write(vecs[v].dev, vecs[v].word, vecs[v].n, vecs[v].data, e_acks);
                check($sformatf("vec%0d_acks", v), acks, vecs[v].exp_acks);
            end
        end

        // Byte cut short by STOP after 4 bits must not be written.
        start_cond();
        write_byte(8'hA0, a); check("cut_stop_dev_ack", {31'h0, a}, 32'h0);
        write_byte(8'h30, a); check("cut_stop_word_ack", {31'h0, a}, 32'h0);
        send_bits(8'h00, 4);
        stop_cond();
        // Byte cut short by repeated START after 5 bits.
        start_cond();
        write_byte(8'hA0, a);
        write_byte(8'h31, a); check("cut_start_word_ack", {31'h0, a}, 32'h0);
        send_bits(8'h00, 5);
        start_cond();
        stop_cond();
        ref_ptr = 8'h31;
        xfer_rand_read(8'hA0, 8'h30, 2, acks, rd);
        model_read(8'hA0, 8'h30, 1'b1, 2, e_acks, e_rd);
        check("cut_bytes_acks", acks, e_acks);
        check("cut_bytes_unwritten", rd, 32'h0000FFFF);

        // Randomised traffic against the model.
        for (int it = 0; it < 24; it++) begin
            op   = int'($urandom_range(0, 2));
            dev  = ($urandom_range(0, 7) == 0) ? 8'hA4 : 8'hA0;
            word = 8'($urandom);
            n    = int'($urandom_range(1, 4));
            data = $urandom;
            if (op == 0) begin
                model_write(dev, word, n, data, e_acks);
                xfer_write(dev, word, n, data, acks);
                check($sformatf("rnd%0d_wr_acks", it), acks, e_acks);
            end else if (op == 1) begin
                model_read(dev, word, 1'b1, n, e_acks, e_rd);
                xfer_rand_read(dev, word, n, acks, rd);
                check($sformatf("rnd%0d_rr_acks", it), acks, e_acks);
                check($sformatf("rnd%0d_rr_data", it), rd, e_rd);
            end else begin
                model_read(dev, word, 1'b0, n, e_acks, e_rd);
                xfer_cur_read(dev, n, acks, rd);
                check($sformatf("rnd%0d_cr_acks", it), acks, e_acks);
                check($sformatf("rnd%0d_cr_data", it), rd, e_rd);
            end
        end

        // Reset while the slave holds SDA low for its address ACK.
        start_cond();
        send_bits(8'hA0, 8);
        #20 m_sda_low = 1'b0;
        #60 m_scl = 1'b1;
        #40 check("ack_before_reset", {31'h0, sda_bus}, 32'h0);
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1 check("async_reset_release", {31'h0, sda_bus}, 32'h1);
        #20 rst_ni = 1'b1;
        model_reset();
        #200;
        xfer_cur_read(8'hA1, 2, acks, rd);
        check("post_reset_cur_acks", acks, 32'h0);
        check("post_reset_cur_data", rd, 32'h0000FFFF);
        xfer_rand_read(8'hA0, 8'h10, 1, acks, rd);
        check("post_reset_mem_erased", rd, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
